tx_frame_scheduler: RTL and testbench

- Sits between the host byte interface and the symbol generator.
- Buffers outgoing messages in a two-bank (ping-pong) message RAM of 2 x 1024 bytes.
- Queues committed banks, then sequences the generator for each one: reset pulse, message length, tick-gated enable, RAM read service, done detection, bank release and inter-frame gap.
- The host can fill one bank while the other is being transmitted.

---
 rtl/tx_pkg.sv | 21 ++
 rtl/msg_ram_2bank.sv | 36 +++
 rtl/tx_frame_scheduler.sv | 140 ++++++++++++++
 tb/tb_tx_frame_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_pkg.sv
// Shared definitions for the transmit frame scheduler: FSM encoding, bank geometry
// and the byte-count to dibit-length conversion.
package tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_GAP   = 2'd3
  } tx_state_t;

  localparam logic [10:0] MAX_BYTES       = 11'd1024;
  localparam int          BANK_ADDR_W     = 10;
  localparam int          DIBITS_PER_BYTE = 4;

  // Generator expects the dibit count minus one; 1024 bytes maps to 4095.
  function automatic logic [15:0] dibit_length(input logic [10:0] n_bytes);
    return ({5'd0, n_bytes} * 16'(DIBITS_PER_BYTE)) - 16'd1;
  endfunction

endpackage

// File: rtl/msg_ram_2bank.sv
// Two-bank message RAM: one write port from the host side, one registered read
// port for the generator. The bank select is the address MSB on both ports.
module msg_ram_2bank
  import tx_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [BANK_ADDR_W:0]   wr_addr,
  input  logic [7:0]             wr_data,
  input  logic                   rd_en,
  input  logic [BANK_ADDR_W:0]   rd_addr,
  output logic [7:0]             rd_data
);

  localparam int DEPTH = 2 ** (BANK_ADDR_W + 1);

  logic [7:0] mem_r [DEPTH];

  // Array storage is not reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read data holds its value between read strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= 8'd0;
    end else if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Ping-pong frame scheduler: the host fills one bank while the generator is
// sequenced through the other, in strict commit order.
module tx_frame_scheduler
  import tx_pkg::*;
#(
  parameter logic [15:0] GAP_TICKS = 16'd64,
  parameter logic [10:0] MAX_BYTES = 11'd1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        wr_last,
  output logic        wr_ready,
  input  logic        abort,
  output logic        gen_reset,
  output logic        gen_enable,
  output logic [15:0] gen_msg_length,
  input  logic        gen_read_enable,
  input  logic [9:0]  gen_ram_addr,
  output logic [7:0]  gen_ram_data,
  input  logic        gen_done,
  output logic        busy,
  output logic [15:0] frames_sent,
  output logic        drop_err
);

  tx_state_t   state_r, state_nxt_s;
  logic [1:0]  full_r, full_nxt_s, set_mask_s, clr_mask_s;
  logic [10:0] len_r [2];
  logic        fill_bank_r, read_bank_r;
  logic [9:0]  waddr_r;
  logic [15:0] gap_cnt_r;
  logic        accept_s, commit_s, run_abort_s, run_done_s, release_s, gap_entry_s;

  assign wr_ready    = ~full_r[fill_bank_r];
  assign accept_s    = wr_en & wr_ready;
  assign commit_s    = accept_s & (wr_last | ({1'b0, waddr_r} == (MAX_BYTES - 11'd1)));
  assign run_abort_s = (state_r == ST_RUN) & abort;
  assign run_done_s  = (state_r == ST_RUN) & gen_done & ~abort;
  assign release_s   = run_abort_s | run_done_s;

  // The committing bank is never the one being released, so both masks apply together.
  assign set_mask_s  = commit_s  ? (2'b01 << fill_bank_r) : 2'b00;
  assign clr_mask_s  = release_s ? (2'b01 << read_bank_r) : 2'b00;
  assign full_nxt_s  = (full_r | set_mask_s) & ~clr_mask_s;
  assign gap_entry_s = (state_nxt_s == ST_GAP) & (state_r != ST_GAP);

  assign gen_enable  = tick & (state_r == ST_RUN) & ~gen_done;
  assign busy        = (state_r != ST_IDLE) | (|full_r);

  // Next-state logic; abort wins over a simultaneous done.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (full_r[read_bank_r]) state_nxt_s = ST_START;
        else                     state_nxt_s = ST_IDLE;
      end
      ST_START: state_nxt_s = ST_RUN;
      ST_RUN: begin
        if (abort)         state_nxt_s = ST_GAP;
        else if (gen_done) state_nxt_s = (GAP_TICKS == 16'd0) ? ST_IDLE : ST_GAP;
        else               state_nxt_s = ST_RUN;
      end
      ST_GAP: begin
        if (gap_cnt_r == 16'd0) state_nxt_s = ST_IDLE;
        else                    state_nxt_s = ST_GAP;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Host fill side and bank bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_r      <= 2'b00;
      len_r[0]    <= 11'd0;
      len_r[1]    <= 11'd0;
      fill_bank_r <= 1'b0;
      read_bank_r <= 1'b0;
      waddr_r     <= 10'd0;
    end else begin
      full_r <= full_nxt_s;
      if (commit_s) begin
        len_r[fill_bank_r] <= {1'b0, waddr_r} + 11'd1;
        fill_bank_r        <= ~fill_bank_r;
        waddr_r            <= 10'd0;
      end else if (accept_s) begin
        waddr_r <= waddr_r + 10'd1;
      end
      if (release_s) begin
        read_bank_r <= ~read_bank_r;
      end
    end
  end

  // Registered generator controls, gap timer and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gen_reset      <= 1'b0;
      gen_msg_length <= 16'd0;
      gap_cnt_r      <= 16'd0;
      frames_sent    <= 16'd0;
      drop_err       <= 1'b0;
    end else begin
      gen_reset <= (state_nxt_s == ST_START) | run_abort_s;
      drop_err  <= wr_en & ~wr_ready;
      if ((state_r == ST_IDLE) && (state_nxt_s == ST_START)) begin
        gen_msg_length <= dibit_length(len_r[read_bank_r]);
      end
      if (run_done_s) begin
        frames_sent <= frames_sent + 16'd1;
      end
      if (gap_entry_s) begin
        gap_cnt_r <= GAP_TICKS;
      end else if ((state_r == ST_GAP) && tick && (gap_cnt_r != 16'd0)) begin
        gap_cnt_r <= gap_cnt_r - 16'd1;
      end
    end
  end

  msg_ram_2bank u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (accept_s),
    .wr_addr ({fill_bank_r, waddr_r}),
    .wr_data (wr_data),
    .rd_en   (gen_read_enable),
    .rd_addr ({read_bank_r, gen_ram_addr}),
    .rd_data (gen_ram_data)
  );

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Scoreboard bench: written bytes and lengths are queued at the host side and
// consumed by a small generator model as frames are started and read back.
module tb_tx_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = 8'd0;
  logic        wr_last = 1'b0;
  logic        abort = 1'b0;
  logic        gen_read_enable = 1'b0;
  logic [9:0]  gen_ram_addr = 10'd0;
  logic        gen_done = 1'b0;
  logic        wr_ready, gen_reset, gen_enable, busy, drop_err;
  logic [15:0] gen_msg_length, frames_sent;
  logic [7:0]  gen_ram_data;

  tx_frame_scheduler #(.GAP_TICKS(16'd64), .MAX_BYTES(11'd1024)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
    .abort(abort), .gen_reset(gen_reset), .gen_enable(gen_enable),
    .gen_msg_length(gen_msg_length), .gen_read_enable(gen_read_enable),
    .gen_ram_addr(gen_ram_addr), .gen_ram_data(gen_ram_data), .gen_done(gen_done),
    .busy(busy), .frames_sent(frames_sent), .drop_err(drop_err)
  );

  always #5 clk = ~clk;

  int   tests_run = 0, tests_failed = 0;
  int   cyc = 0, tick_total = 0, tick_div = 0;
  logic tick_force = 1'b0;
  logic [7:0] exp_bytes[$];
  int   exp_len[$];
  int   start_cnt = 0, handled = 0, cur_len = 0, start_cyc = 0, start_ticks = 0;
  int   commit_cyc = 0, done_ticks = 0, exp_frames = 0, msg_bytes = 0;
  bit   in_abort = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    if (tick) tick_total++;
  end

  // Sample-rate strobe every 4th cycle unless forced high.
  initial forever begin
    @(negedge clk);
    tick_div = (tick_div == 3) ? 0 : tick_div + 1;
    tick = tick_force | (tick_div == 0);
  end

  // Frame-start monitor: each non-abort gen_reset pulse consumes one queued length.
  initial forever begin
    @(negedge clk);
    if (!reset && gen_reset && !in_abort) begin
      start_cnt++;
      start_cyc = cyc;
      start_ticks = tick_total;
      check_eq("start_queued", 32'(exp_len.size() != 0), 32'd1);
      if (exp_len.size() != 0) begin
        cur_len = exp_len.pop_front();
        check_eq("msg_length", 32'(gen_msg_length), 32'(4 * cur_len - 1));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_byte(input logic [7:0] d, input logic last, input bit accepted);
    wr_en = 1'b1;
    wr_data = d;
    wr_last = last;
    if (accepted) begin
      exp_bytes.push_back(d);
      msg_bytes++;
      if (last || msg_bytes == 1024) begin
        exp_len.push_back(msg_bytes);
        msg_bytes = 0;
        commit_cyc = cyc;
      end
    end
    @(negedge clk);
    if (accepted) check_eq("no_drop", 32'(drop_err), 32'd0);
    else          check_eq("drop_err", 32'(drop_err), 32'd1);
  endtask

  task automatic end_write();
    wr_en = 1'b0;
    wr_last = 1'b0;
  endtask

  // Generator model. mode 0: done pulse, 1: done with forced tick, 2: abort, 3: abort+done.
  task automatic run_frame(input int mode);
    int n;
    int waited;
    waited = 0;
    while (start_cnt <= handled && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check_eq("frame_started", 32'(start_cnt > handled), 32'd1);
    if (start_cnt > handled) begin
      handled = start_cnt;
      n = (mode >= 2) ? 1 : cur_len;
      for (int i = 0; i <= n; i++) begin
        if (i > 0) begin
          if (exp_bytes.size() != 0) check_eq("ram_data", 32'(gen_ram_data), 32'(exp_bytes.pop_front()));
          else                       check_eq("ram_data_queued", 32'd0, 32'd1);
        end
        gen_read_enable = (i < n);
        gen_ram_addr = 10'(i);
        @(negedge clk);
      end
      case (mode)
        0: begin
          gen_done = 1'b1;
          @(negedge clk);
          gen_done = 1'b0;
          exp_frames++;
          done_ticks = tick_total;
          check_eq("frames_sent", 32'(frames_sent), 32'(exp_frames));
          check_eq("wr_ready_after_done", 32'(wr_ready), 32'd1);
        end
        1: begin
          tick_force = 1'b1;
          @(negedge clk);
          #1;
          check_eq("enable_in_run", 32'(gen_enable), 32'd1);
          gen_done = 1'b1;
          #1;
          check_eq("enable_gated_by_done", 32'(gen_enable), 32'd0);
          @(negedge clk);
          exp_frames++;
          check_eq("frames_sent_hold", 32'(frames_sent), 32'(exp_frames));
          gen_done = 1'b0;
          #1;
          check_eq("enable_after_run", 32'(gen_enable), 32'd0);
          tick_force = 1'b0;
          @(negedge clk);
        end
        default: begin
          in_abort = 1'b1;
          abort = 1'b1;
          if (mode == 3) gen_done = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          gen_done = 1'b0;
          check_eq("abort_reset", 32'(gen_reset), 32'd1);
          check_eq("abort_count", 32'(frames_sent), 32'(exp_frames));
          for (int i = 1; i < cur_len; i++) begin
            if (exp_bytes.size() != 0) void'(exp_bytes.pop_front());
          end
          waited = 0;
          while (busy && waited < 1000) begin
            @(negedge clk);
            waited++;
          end
          check_eq("abort_released", 32'(busy), 32'd0);
          check_eq("abort_wr_ready", 32'(wr_ready), 32'd1);
          in_abort = 1'b0;
        end
      endcase
    end
  endtask

  initial begin
    int gap_done;
    repeat (3) @(negedge clk);
    check_eq("rst_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_frames", 32'(frames_sent), 32'd0);
    check_eq("rst_gen_reset", 32'(gen_reset), 32'd0);
    check_eq("rst_len", 32'(gen_msg_length), 32'd0);
    check_eq("rst_drop", 32'(drop_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Short message and commit-to-start latency.
    write_byte(8'hA5, 1'b0, 1'b1);
    write_byte(8'h3C, 1'b0, 1'b1);
    write_byte(8'hFF, 1'b1, 1'b1);
    end_write();
    run_frame(0);
    check_eq("commit_to_reset", 32'(start_cyc - commit_cyc), 32'd2);

    // Full bank auto-commit, then one byte into the other bank.
    for (int i = 0; i < 1024; i++) write_byte(8'($urandom), 1'b0, 1'b1);
    write_byte(8'hE7, 1'b1, 1'b1);
    end_write();
    run_frame(0);
    run_frame(0);

    // Both banks full: third message is dropped; frames separated by the gap.
    for (int i = 0; i < 5; i++) write_byte(8'(8'h40 + i), (i == 4), 1'b1);
    for (int i = 0; i < 4; i++) write_byte(8'(8'h90 + i), (i == 3), 1'b1);
    check_eq("wr_ready_both_full", 32'(wr_ready), 32'd0);
    for (int i = 0; i < 3; i++) write_byte(8'(8'hD0 + i), (i == 2), 1'b0);
    end_write();
    @(negedge clk);
    check_eq("drop_clear", 32'(drop_err), 32'd0);
    run_frame(0);
    gap_done = done_ticks;
    run_frame(0);
    check_eq("gap_ticks", 32'(start_ticks - gap_done), 32'd64);

    // Done held high with tick high.
    write_byte(8'h81, 1'b0, 1'b1);
    write_byte(8'h82, 1'b1, 1'b1);
    end_write();
    run_frame(1);

    // Abort alone, then abort together with done.
    for (int i = 0; i < 3; i++) write_byte(8'(8'h20 + i), (i == 2), 1'b1);
    end_write();
    run_frame(2);
    for (int i = 0; i < 3; i++) write_byte(8'(8'h30 + i), (i == 2), 1'b1);
    end_write();
    run_frame(3);

    // Reset in RUN with both banks full.
    write_byte(8'h11, 1'b0, 1'b1);
    write_byte(8'h22, 1'b1, 1'b1);
    write_byte(8'h33, 1'b0, 1'b1);
    write_byte(8'h44, 1'b1, 1'b1);
    end_write();
    for (int k = 0; k < 100 && start_cnt <= handled; k++) @(negedge clk);
    check_eq("pre_reset_start", 32'(start_cnt > handled), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_gen_reset", 32'(gen_reset), 32'd0);
    check_eq("mid_rst_wr_ready", 32'(wr_ready), 32'd1);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_frames", 32'(frames_sent), 32'd0);
    check_eq("mid_rst_len", 32'(gen_msg_length), 32'd0);
    check_eq("mid_rst_ram_data", 32'(gen_ram_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_bytes.delete();
    exp_len.delete();
    exp_frames = 0;
    msg_bytes = 0;
    handled = start_cnt;
    @(negedge clk);
    write_byte(8'h5A, 1'b0, 1'b1);
    write_byte(8'hC3, 1'b0, 1'b1);
    write_byte(8'h99, 1'b1, 1'b1);
    end_write();
    run_frame(0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
